// File: rtl/cpu_register_file_dma.sv
// Bulk LOAD/DUMP byte engine in front of a CPU register file: one command at a time.
// Optional running checksum port enabled by defining CPU_REGISTER_FILE_DMA_CHECKSUM_EN.
module cpu_register_file_dma #(
  parameter int  NUMBER_OF_REGISTERS = 256,
  localparam int ADDR_W              = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              command_valid_in,
  output logic              command_ready_out,
  input  logic              command_is_dump_in,
  input  logic [ADDR_W-1:0] command_start_address_in,
  input  logic [ADDR_W:0]   command_length_in,
  input  logic              stream_in_valid_in,
  input  logic [7:0]        stream_in_data_in,
  output logic              stream_in_ready_out,
  output logic              stream_out_valid_out,
  output logic [7:0]        stream_out_data_out,
  input  logic              stream_out_ready_in,
  output logic              rf_write_enable_out,
  output logic [ADDR_W-1:0] rf_write_register_address_out,
  output logic [7:0]        rf_write_data_out,
  output logic [ADDR_W-1:0] rf_read_register_address_out,
  input  logic [7:0]        rf_read_data_in,
  output logic              busy_out,
  output logic              done_out
`ifdef CPU_REGISTER_FILE_DMA_CHECKSUM_EN
  ,
  output logic [7:0]        checksum_out
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP, S_DONE} state_t;

  localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(NUMBER_OF_REGISTERS);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUMBER_OF_REGISTERS-1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [ADDR_W:0]   remain_q, remain_d, len_clamped;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              out_vld_q, out_vld_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              remain_zero, cmd_acc, in_acc, out_hs, out_ld;

  assign len_clamped = (command_length_in > LEN_MAX) ? LEN_MAX : command_length_in;
  assign remain_zero = (remain_q == '0);
  assign addr_inc    = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
  assign cmd_acc     = command_valid_in && command_ready_out;
  assign in_acc      = stream_in_valid_in && stream_in_ready_out;
  assign out_hs      = out_vld_q && stream_out_ready_in;
  // Output register refills whenever it is empty or being drained this cycle.
  assign out_ld      = (state_q == S_DUMP) && !remain_zero && (!out_vld_q || stream_out_ready_in);

  always_ff @(posedge clock_in) begin
    if (reset_in) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          if (len_clamped == '0)      state_d = S_DONE;
          else if (command_is_dump_in) state_d = S_DUMP;
          else                         state_d = S_LOAD;
        end
      end
      // Leave LOAD only once the last byte's write pulse is on the bus.
      S_LOAD:  if (remain_zero && wr_en_q) state_d = S_DONE;
      S_DUMP:  if (remain_zero && out_hs)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    command_ready_out   = 1'b0;
    busy_out            = 1'b1;
    done_out            = 1'b0;
    stream_in_ready_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        command_ready_out = 1'b1;
        busy_out          = 1'b0;
      end
      S_LOAD:  stream_in_ready_out = !remain_zero;
      S_DONE:  done_out = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    remain_d   = remain_q;
    wr_en_d    = in_acc;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (cmd_acc) begin
      addr_d   = command_start_address_in;
      remain_d = len_clamped;
    end
    if (in_acc) begin
      wr_addr_d = addr_q;
      wr_data_d = stream_in_data_in;
      addr_d    = addr_inc;
      remain_d  = remain_q - LEN_ONE;
    end
    if (out_ld) begin
      out_data_d = rf_read_data_in;
      out_vld_d  = 1'b1;
      addr_d     = addr_inc;
      remain_d   = remain_q - LEN_ONE;
    end else if (out_hs) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      addr_q     <= '0;
      remain_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign rf_write_enable_out           = wr_en_q;
  assign rf_write_register_address_out = wr_addr_q;
  assign rf_write_data_out             = wr_data_q;
  assign rf_read_register_address_out  = addr_q;
  assign stream_out_valid_out          = out_vld_q;
  assign stream_out_data_out           = out_data_q;

`ifdef CPU_REGISTER_FILE_DMA_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (cmd_acc)     csum_d = '0;
    else if (in_acc) csum_d = csum_q + stream_in_data_in;
    else if (out_hs) csum_d = csum_q + out_data_q;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign checksum_out = csum_q;
`endif

endmodule

// File: tb/tb_cpu_register_file_dma.sv
// Directed bench for cpu_register_file_dma with a register-file model and write/read scoreboards.
module tb_cpu_register_file_dma;
  localparam int N  = 256;
  localparam int AW = 8;

  logic          clock_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          command_valid_in = 1'b0;
  logic          command_ready_out;
  logic          command_is_dump_in = 1'b0;
  logic [AW-1:0] command_start_address_in = '0;
  logic [AW:0]   command_length_in = '0;
  logic          stream_in_valid_in = 1'b0;
  logic [7:0]    stream_in_data_in = '0;
  logic          stream_in_ready_out;
  logic          stream_out_valid_out;
  logic [7:0]    stream_out_data_out;
  logic          stream_out_ready_in = 1'b0;
  logic          rf_write_enable_out;
  logic [AW-1:0] rf_write_register_address_out;
  logic [7:0]    rf_write_data_out;
  logic [AW-1:0] rf_read_register_address_out;
  logic [7:0]    rf_read_data_in;
  logic          busy_out;
  logic          done_out;
`ifdef CPU_REGISTER_FILE_DMA_CHECKSUM_EN
  logic [7:0]    checksum_out;
`endif

  always #5 clock_in = ~clock_in;

  cpu_register_file_dma #(.NUMBER_OF_REGISTERS(N)) dut (
    .clock_in                      (clock_in),
    .reset_in                      (reset_in),
    .command_valid_in              (command_valid_in),
    .command_ready_out             (command_ready_out),
    .command_is_dump_in            (command_is_dump_in),
    .command_start_address_in      (command_start_address_in),
    .command_length_in             (command_length_in),
    .stream_in_valid_in            (stream_in_valid_in),
    .stream_in_data_in             (stream_in_data_in),
    .stream_in_ready_out           (stream_in_ready_out),
    .stream_out_valid_out          (stream_out_valid_out),
    .stream_out_data_out           (stream_out_data_out),
    .stream_out_ready_in           (stream_out_ready_in),
    .rf_write_enable_out           (rf_write_enable_out),
    .rf_write_register_address_out (rf_write_register_address_out),
    .rf_write_data_out             (rf_write_data_out),
    .rf_read_register_address_out  (rf_read_register_address_out),
    .rf_read_data_in               (rf_read_data_in),
    .busy_out                      (busy_out),
    .done_out                      (done_out)
`ifdef CPU_REGISTER_FILE_DMA_CHECKSUM_EN
    ,
    .checksum_out                  (checksum_out)
`endif
  );

  // Register file model: registered write, combinational read.
  logic [7:0] mem [N] = '{default: 8'h00};
  assign rf_read_data_in = mem[rf_read_register_address_out];
  always @(posedge clock_in)
    if (rf_write_enable_out) mem[rf_write_register_address_out] <= rf_write_data_out;

  int checks = 0;
  int errors = 0;
  logic [15:0] wq [$];
  logic [7:0]  rq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pops on every write pulse / output handshake; also checks stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clock_in) begin
    if (rf_write_enable_out) begin
      if (wq.size() == 0) chk("wr_unexpected", rf_write_enable_out, 0);
      else chk("wr_addr_data", {rf_write_register_address_out, rf_write_data_out}, wq.pop_front());
    end
    if (stream_out_valid_out && stream_out_ready_in) begin
      if (rq.size() == 0) chk("rd_unexpected", stream_out_valid_out, 0);
      else chk("rd_data", stream_out_data_out, rq.pop_front());
    end
    if (prev_stall) begin
      chk("stall_valid", stream_out_valid_out, 1);
      chk("stall_data", stream_out_data_out, prev_data);
    end
    prev_stall = stream_out_valid_out && !stream_out_ready_in;
    prev_data  = stream_out_data_out;
  end

  task automatic offer(input logic dump, input int addr, input int len);
    int w;
    command_is_dump_in       = dump;
    command_start_address_in = AW'(addr);
    command_length_in        = (AW+1)'(len);
    command_valid_in         = 1'b1;
    w = 0;
    @(negedge clock_in);
    while (!command_ready_out && w < 20) begin
      @(posedge clock_in); #1;
      @(negedge clock_in);
      w++;
    end
    chk("cmd_accept", command_ready_out, 1);
    @(posedge clock_in); #1;
    command_valid_in = 1'b0;
  endtask

  task automatic load_run(input int addr, input int n, input logic [7:0] bytes [4]);
    for (int i = 0; i < n; i++) begin
      int w;
      wq.push_back({8'(addr + i), bytes[i]});
      stream_in_valid_in = 1'b1;
      stream_in_data_in  = bytes[i];
      w = 0;
      @(negedge clock_in);
      while (!stream_in_ready_out && w < 20) begin
        @(negedge clock_in);
        w++;
      end
      chk("in_ready", stream_in_ready_out, 1);
      @(posedge clock_in); #1;
    end
    stream_in_valid_in = 1'b0;
    @(negedge clock_in);
    chk("last_pulse", rf_write_enable_out, 1);
    chk("in_ready_drop", stream_in_ready_out, 0);
    chk("no_early_done", done_out, 0);
    @(negedge clock_in);
    chk("load_done", done_out, 1);
    chk("done_busy", busy_out, 1);
    chk("done_no_we", rf_write_enable_out, 0);
  endtask

  task automatic dump_run(input int n, input logic [7:0] pat, output int first, output int last);
    int hs;
    logic [7:0] p;
    hs = 0; first = -1; last = -1; p = pat;
    for (int c = 0; c < n + 40; c++) begin
      stream_out_ready_in = (c < 8) ? p[0] : 1'b1;
      p = p >> 1;
      @(negedge clock_in);
      if (command_valid_in) chk("busy_not_ready", command_ready_out, 0);
      if (stream_out_valid_out && stream_out_ready_in) begin
        if (hs == 0) first = c;
        last = c;
        hs++;
      end
      if (hs == n) break;
      @(posedge clock_in); #1;
    end
    chk("dump_count", hs, n);
    @(posedge clock_in); #1;
    @(negedge clock_in);
    chk("dump_done", done_out, 1);
    chk("dump_valid_off", stream_out_valid_out, 0);
    chk("dump_done_not_ready", command_ready_out, 0);
    stream_out_ready_in = 1'b0;
  endtask

  task automatic idle_after();
    @(negedge clock_in);
    chk("idle_done_low", done_out, 0);
    chk("idle_ready", command_ready_out, 1);
    chk("idle_busy", busy_out, 0);
    chk("idle_we", rf_write_enable_out, 0);
    chk("idle_ovalid", stream_out_valid_out, 0);
    @(posedge clock_in); #1;
  endtask

  initial begin
    logic [7:0] bv [4];
    int first, last;
    logic [7:0] sum;

    repeat (2) @(posedge clock_in);
    #1;
    @(negedge clock_in);
    chk("rst_ready", command_ready_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_we", rf_write_enable_out, 0);
    chk("rst_wr", {rf_write_register_address_out, rf_write_data_out}, 0);
    chk("rst_in_ready", stream_in_ready_out, 0);
    chk("rst_out", {stream_out_valid_out, stream_out_data_out}, 0);
    chk("rst_raddr", rf_read_register_address_out, 0);
    @(posedge clock_in); #1;
    reset_in = 1'b0;

    // LOAD 0x10 x4
    bv = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    offer(1'b0, 8'h10, 4);
    load_run(8'h10, 4, bv);
`ifdef CPU_REGISTER_FILE_DMA_CHECKSUM_EN
    chk("csum_load", checksum_out, 8'h8A);
`endif
    idle_after();

    // LOAD across the top-of-file wrap
    bv = '{8'h01, 8'h02, 8'h03, 8'h00};
    offer(1'b0, 8'hFE, 3);
    load_run(8'hFE, 3, bv);
    idle_after();
    @(negedge clock_in);
    chk("wrap_r00", mem[0], 8'h03);
    chk("wrap_rff", mem[255], 8'h02);
    chk("wrap_r01_untouched", mem[1], 8'h00);
    @(posedge clock_in); #1;

    // DUMP 0x10 x3 with ready 1,0,0,1,1
    rq.push_back(8'hA1); rq.push_back(8'hA2); rq.push_back(8'hA3);
    offer(1'b1, 8'h10, 3);
    dump_run(3, 8'b1111_1001, first, last);
    chk("dump_first_hs", first, 3);
    chk("dump_last_hs", last, 5);
`ifdef CPU_REGISTER_FILE_DMA_CHECKSUM_EN
    chk("csum_dump", checksum_out, 8'hE6);
`endif
    idle_after();

    // Zero-length commands of both kinds
    for (int d = 0; d < 2; d++) begin
      offer(d[0], 8'h20, 0);
      @(negedge clock_in);
      chk("len0_done", done_out, 1);
      chk("len0_we", rf_write_enable_out, 0);
      chk("len0_ovalid", stream_out_valid_out, 0);
      chk("len0_in_ready", stream_in_ready_out, 0);
`ifdef CPU_REGISTER_FILE_DMA_CHECKSUM_EN
      chk("len0_csum", checksum_out, 0);
`endif
      idle_after();
    end

    // Reset while the second LOAD byte is being accepted
    wq.push_back({8'h40, 8'h11});
    offer(1'b0, 8'h40, 4);
    stream_in_valid_in = 1'b1;
    stream_in_data_in  = 8'h11;
    @(negedge clock_in);
    chk("t5_in_ready", stream_in_ready_out, 1);
    @(posedge clock_in); #1;
    stream_in_data_in = 8'h22;
    reset_in = 1'b1;
    @(negedge clock_in);
    chk("t5_pulse1", rf_write_enable_out, 1);
    @(posedge clock_in); #1;
    reset_in = 1'b0;
    stream_in_valid_in = 1'b0;
    @(negedge clock_in);
    chk("t5_we", rf_write_enable_out, 0);
    chk("t5_ready", command_ready_out, 1);
    chk("t5_busy", busy_out, 0);
    chk("t5_in_ready_off", stream_in_ready_out, 0);
    chk("t5_wr_bus", {rf_write_register_address_out, rf_write_data_out}, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_done", done_out, 0);
      @(negedge clock_in);
    end
    chk("t5_r40", mem[8'h40], 8'h11);
    chk("t5_r41", mem[8'h41], 8'h00);
    @(posedge clock_in); #1;

    // DUMP len 300 clamps to 256; a LOAD is held on the command port throughout
    sum = '0;
    for (int i = 0; i < N; i++) begin
      rq.push_back(mem[i]);
      sum = sum + mem[i];
    end
    offer(1'b1, 0, 300);
    command_is_dump_in       = 1'b0;
    command_start_address_in = 8'h05;
    command_length_in        = 9'd1;
    command_valid_in         = 1'b1;
    dump_run(N, 8'hFF, first, last);
    chk("throughput", last - first, N - 1);
`ifdef CPU_REGISTER_FILE_DMA_CHECKSUM_EN
    chk("csum_clamp", checksum_out, sum);
`endif
    @(negedge clock_in);
    chk("t6_ready_idle", command_ready_out, 1);
    @(posedge clock_in); #1;
    command_valid_in = 1'b0;
    bv = '{8'h5A, 8'h00, 8'h00, 8'h00};
    load_run(8'h05, 1, bv);
    idle_after();
    @(negedge clock_in);
    chk("t6_r05", mem[5], 8'h5A);

    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
